wb_port_arbiter: RTL and testbench
==================================

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 Parameter: DEPTH, default 2, number of entries in the multi-cycle result buffer (power of two, 2..8).
REQ-002 clk  in  1  rising-edge clock shared with the register file.
REQ-003 rst_n  in  1  reset, asynchronous and active-low.
REQ-004 pipe_we  in  1  pipeline write-back request, never back-pressured.
REQ-005 pipe_addr  in  5  pipeline destination register.
REQ-006 pipe_data  in  32  pipeline result.
REQ-007 md_valid  in  1  mul/div result valid.
REQ-008 md_addr  in  5  mul/div destination register.
REQ-009 md_data  in  32  mul/div result.
REQ-010 md_ready  out  1  buffer can accept a mul/div result.
REQ-011 md_issue  in  1  mul/div operation issued this cycle.
REQ-012 md_issue_addr  in  5  destination of the issued operation.
REQ-013 id_rs_addr, id_rt_addr  in  5 each  decode-stage source registers.
REQ-014 stall  out  1  decode must hold (RAW hazard on a pending mul/div result).
REQ-015 register_write  out  1  register-file write enable.
REQ-016 write_addr  out  5  register-file write address.
REQ-017 write_result  out  32  register-file write data.
REQ-018 buf_count  out  log2(DEPTH)+1  entries currently buffered.

Function
REQ-019 Shall share the single register-file write port between the pipeline and the mul/div unit.
REQ-020 Pipeline request is valid only when pipe_we=1 and pipe_addr!=0; otherwise it is ignored.
REQ-021 md_ready shall be 1 iff rst_n=1 and buf_count<DEPTH; it shall not depend on a same-cycle pop.
REQ-022 A mul/div result is accepted when md_valid=1 and md_ready=1.
  - Accepted with md_addr=0: discarded, not buffered.
  - Otherwise: pushed into a FIFO.
REQ-023 Arbitration each cycle is fixed priority.
  - Valid pipeline request wins.
  - Otherwise the FIFO head is popped if the FIFO is non-empty.
  - Otherwise no write.
REQ-024 Winner is registered: register_write/write_addr/write_result update at the next rising edge (latency 1). With no winner, register_write=0 and addr/data hold.
REQ-025 Mul/div results always pass through the FIFO. Minimum latency from acceptance to register_write is 2 cycles, with no bypass.
REQ-026 A push and a pop in the same cycle leave buf_count unchanged. The FIFO read/write pointers shall wrap modulo DEPTH.
REQ-027 Shall keep a 32-bit pending scoreboard.
  - Bit set at the edge where md_issue=1 and md_issue_addr!=0.
  - Bit 0 is never set.
REQ-028 A registered flag shall mark an output write that was sourced from the FIFO.
  - At the edge where register_write=1 with that flag set, pending[write_addr] clears (commit edge).
  - A simultaneous set and clear of the same bit resolves to set.
REQ-029 Re-issue to an already-pending address leaves the bit set; one commit clears it.
REQ-030 stall shall be combinational and equal (id_rs_addr!=0 && pending[id_rs_addr]) || (id_rt_addr!=0 && pending[id_rt_addr]).
  - stall stays asserted through the commit cycle.
  - stall deasserts the cycle after the commit edge.
REQ-031 A FIFO head may wait indefinitely while pipeline requests continue. Dependent stalls throttle the pipeline, so starvation resolves once the pipeline drains.

Reset
REQ-032 While rst_n=0, the following shall hold:
  - register_write=0, write_addr=0, write_result=0.
  - buf_count=0, FIFO pointers=0.
  - Pending scoreboard=0, stall=0, md_ready=0.
REQ-033 Reset mid-operation shall discard all buffered results and pending bits with no write emitted. md_ready=1 in the first cycle after rst_n rises.

Verification
REQ-034 Pipe-only: pipe_we=1, addr=5, data=0xAAAA0001 -> next cycle register_write=1, write_addr=5, write_result=0xAAAA0001; addr=0 -> register_write=0.
REQ-035 Conflict: pipe write r3 and md_valid r7=0x1234 in the same cycle with FIFO empty -> cycle+1 writes r3; cycle+2 writes r7=0x1234; buf_count 1 then 0.
REQ-036 Full: DEPTH=2, push r1 and r2 while pipe_we=1 continuously -> buf_count=2, md_ready=0, third md_valid not accepted; drop pipe_we -> r1 then r2 written in order, md_ready returns 1.
REQ-037 Hazard: md_issue r9; id_rs_addr=9 -> stall=1 until the r9 commit cycle inclusive, stall=0 the following cycle; id_rt_addr=0 never stalls.
REQ-038 Issue/commit overlap: commit of r4 at the same edge as md_issue r4 -> pending[4] remains 1, stall on r4 persists.
REQ-039 Reset: with buf_count=2 and pending r9, pulse rst_n low between edges -> all outputs 0 immediately, no write of r1/r2 afterwards, stall=0.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares one register-file write port between the pipeline and a buffered mul/div unit,
// and tracks mul/div results that are still in flight so decode can stall on RAW hazards.
module wb_port_arbiter #(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       pipe_we,
    input  logic [4:0]                 pipe_addr,
    input  logic [31:0]                pipe_data,
    input  logic                       md_valid,
    input  logic [4:0]                 md_addr,
    input  logic [31:0]                md_data,
    output logic                       md_ready,
    input  logic                       md_issue,
    input  logic [4:0]                 md_issue_addr,
    input  logic [4:0]                 id_rs_addr,
    input  logic [4:0]                 id_rt_addr,
    output logic                       stall,
    output logic                       register_write,
    output logic [4:0]                 write_addr,
    output logic [31:0]                write_result,
    output logic [$clog2(DEPTH):0]     buf_count
);
    localparam int AW = $clog2(DEPTH);

    logic [4:0]    addr_mem [DEPTH];
    logic [31:0]   data_mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   cnt_q, cnt_d;
    logic [31:0]   pending_q, pending_d, set_mask, clr_mask;
    logic          we_q, we_d, from_fifo_q, from_fifo_d;
    logic [4:0]    waddr_q, waddr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          pipe_v, push, pop;

    assign pipe_v   = pipe_we && (pipe_addr != 5'd0);
    assign md_ready = rst_n && (cnt_q < (AW+1)'(DEPTH));
    assign push     = md_valid && md_ready && (md_addr != 5'd0);
    assign pop      = !pipe_v && (cnt_q != '0);
    assign cnt_d    = cnt_q + (AW+1)'(push) - (AW+1)'(pop);

    always_comb begin
        we_d        = pipe_v || pop;
        from_fifo_d = !pipe_v && pop;
        waddr_d     = pipe_v ? pipe_addr : pop ? addr_mem[rd_ptr_q] : waddr_q;
        wdata_d     = pipe_v ? pipe_data : pop ? data_mem[rd_ptr_q] : wdata_q;
    end

    // A commit and a re-issue of the same register on one edge must leave the bit set.
    assign set_mask  = (md_issue && (md_issue_addr != 5'd0)) ? (32'd1 << md_issue_addr) : 32'd0;
    assign clr_mask  = (we_q && from_fifo_q) ? (32'd1 << waddr_q) : 32'd0;
    assign pending_d = (pending_q & ~clr_mask) | set_mask;

    assign stall = ((id_rs_addr != 5'd0) && pending_q[id_rs_addr]) ||
                   ((id_rt_addr != 5'd0) && pending_q[id_rt_addr]);

    assign register_write = we_q;
    assign write_addr     = waddr_q;
    assign write_result   = wdata_q;
    assign buf_count      = cnt_q;

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr_q] <= md_addr;
            data_mem[wr_ptr_q] <= md_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            pending_q   <= '0;
            we_q        <= 1'b0;
            from_fifo_q <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_q + AW'(push);
            rd_ptr_q    <= rd_ptr_q + AW'(pop);
            cnt_q       <= cnt_d;
            pending_q   <= pending_d;
            we_q        <= we_d;
            from_fifo_q <= from_fifo_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
        end
    end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed vectors for wb_port_arbiter with hand-computed expectations.
module tb_wb_port_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pipe_we = 1'b0;
    logic [4:0]  pipe_addr = '0;
    logic [31:0] pipe_data = '0;
    logic        md_valid = 1'b0;
    logic [4:0]  md_addr = '0;
    logic [31:0] md_data = '0;
    logic        md_ready;
    logic        md_issue = 1'b0;
    logic [4:0]  md_issue_addr = '0;
    logic [4:0]  id_rs_addr = '0;
    logic [4:0]  id_rt_addr = '0;
    logic        stall;
    logic        register_write;
    logic [4:0]  write_addr;
    logic [31:0] write_result;
    logic [1:0]  buf_count;
    int          n_chk = 0;
    int          n_pass = 0;

    wb_port_arbiter #(.DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .pipe_we(pipe_we), .pipe_addr(pipe_addr), .pipe_data(pipe_data),
        .md_valid(md_valid), .md_addr(md_addr), .md_data(md_data), .md_ready(md_ready),
        .md_issue(md_issue), .md_issue_addr(md_issue_addr),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .stall(stall),
        .register_write(register_write), .write_addr(write_addr),
        .write_result(write_result), .buf_count(buf_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        step();
        step();
        chk("rst_we", 32'(register_write), 0);
        chk("rst_addr", 32'(write_addr), 0);
        chk("rst_data", write_result, 0);
        chk("rst_cnt", 32'(buf_count), 0);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_ready", 32'(md_ready), 0);
        rst_n = 1'b1;
        #1;
        chk("ready_after_rst", 32'(md_ready), 1);

        pipe_we = 1; pipe_addr = 5; pipe_data = 32'hAAAA0001;
        step();
        chk("pipe_we", 32'(register_write), 1);
        chk("pipe_addr", 32'(write_addr), 5);
        chk("pipe_data", write_result, 32'hAAAA0001);
        pipe_addr = 0; pipe_data = 32'h5555;
        step();
        chk("pipe_r0_we", 32'(register_write), 0);
        chk("pipe_r0_hold", 32'(write_addr), 5);

        pipe_addr = 3; pipe_data = 32'h33;
        md_valid = 1; md_addr = 7; md_data = 32'h1234;
        step();
        pipe_we = 0; md_valid = 0;
        chk("conf_c1_addr", 32'(write_addr), 3);
        chk("conf_c1_cnt", 32'(buf_count), 1);
        step();
        chk("conf_c2_we", 32'(register_write), 1);
        chk("conf_c2_addr", 32'(write_addr), 7);
        chk("conf_c2_data", write_result, 32'h1234);
        chk("conf_c2_cnt", 32'(buf_count), 0);
        step();
        chk("conf_idle", 32'(register_write), 0);

        pipe_we = 1; pipe_addr = 10; pipe_data = 32'hA0;
        md_valid = 1; md_addr = 1; md_data = 32'h11;
        step();
        chk("full_cnt1", 32'(buf_count), 1);
        md_addr = 2; md_data = 32'h22;
        step();
        chk("full_cnt2", 32'(buf_count), 2);
        chk("full_ready", 32'(md_ready), 0);
        md_addr = 3; md_data = 32'h33;
        step();
        chk("full_reject", 32'(buf_count), 2);
        chk("full_pipe_wins", 32'(write_addr), 10);
        md_valid = 0; pipe_we = 0;
        step();
        chk("drain1_addr", 32'(write_addr), 1);
        chk("drain1_data", write_result, 32'h11);
        chk("drain1_ready", 32'(md_ready), 1);
        step();
        chk("drain2_addr", 32'(write_addr), 2);
        chk("drain2_data", write_result, 32'h22);
        chk("drain2_cnt", 32'(buf_count), 0);
        step();
        chk("drain_no_r3", 32'(register_write), 0);

        md_issue = 1; md_issue_addr = 9; id_rs_addr = 9; id_rt_addr = 0;
        #1;
        chk("haz_pre", 32'(stall), 0);
        step();
        md_issue = 0;
        chk("haz_set", 32'(stall), 1);
        id_rs_addr = 0; id_rt_addr = 9;
        #1;
        chk("haz_rt", 32'(stall), 1);
        id_rs_addr = 9; id_rt_addr = 0;
        md_valid = 1; md_addr = 9; md_data = 32'h99;
        step();
        md_valid = 0;
        chk("haz_buf", 32'(stall), 1);
        step();
        chk("haz_commit_we", 32'(register_write), 1);
        chk("haz_commit_addr", 32'(write_addr), 9);
        chk("haz_commit_stall", 32'(stall), 1);
        step();
        chk("haz_clear", 32'(stall), 0);
        md_issue = 1; md_issue_addr = 0; id_rs_addr = 0;
        step();
        md_issue = 0;
        chk("haz_r0", 32'(stall), 0);

        md_issue = 1; md_issue_addr = 4; id_rs_addr = 4;
        step();
        md_issue = 0;
        chk("ovl_set", 32'(stall), 1);
        md_valid = 1; md_addr = 4; md_data = 32'h44;
        step();
        md_valid = 0;
        step();
        chk("ovl_commit_addr", 32'(write_addr), 4);
        md_issue = 1; md_issue_addr = 4;
        step();
        md_issue = 0;
        chk("ovl_keep", 32'(stall), 1);
        step();
        chk("ovl_keep2", 32'(stall), 1);
        md_valid = 1; md_addr = 4; md_data = 32'h45;
        step();
        md_valid = 0;
        step();
        step();
        chk("ovl_clear", 32'(stall), 0);

        md_issue = 1; md_issue_addr = 9; id_rs_addr = 9;
        pipe_we = 1; pipe_addr = 12; pipe_data = 32'hC0;
        md_valid = 1; md_addr = 1; md_data = 32'h11;
        step();
        md_issue = 0; md_addr = 2; md_data = 32'h22;
        step();
        md_valid = 0;
        chk("rr_cnt", 32'(buf_count), 2);
        chk("rr_stall", 32'(stall), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rr_we", 32'(register_write), 0);
        chk("rr_addr", 32'(write_addr), 0);
        chk("rr_data", write_result, 0);
        chk("rr_cnt0", 32'(buf_count), 0);
        chk("rr_stall0", 32'(stall), 0);
        chk("rr_ready0", 32'(md_ready), 0);
        pipe_we = 0;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rr_no_write", 32'(register_write), 0);
        end
        chk("rr_stall_after", 32'(stall), 0);
        chk("rr_ready_after", 32'(md_ready), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
